// File: rtl/gps_time_keeper.sv
// gps_time_keeper: local time-of-day clock that resyncs to valid GPS UTC, coasts between fixes and reports sync/holdover status
module gps_time_keeper #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TZ_HR      = 0,
    parameter int HOLDOVER_S = 5,
    parameter int LOST_S     = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] gps_hr,
    input  logic [5:0] gps_min,
    input  logic [5:0] gps_sec,
    input  logic       gps_NSR,
    output logic [4:0] loc_hr,
    output logic [5:0] loc_min,
    output logic [5:0] loc_sec,
    output logic       time_valid,
    output logic       holdover,
    output logic       sec_pulse
);
    localparam int PW = $clog2(CLK_HZ);
    localparam int SW = $clog2(LOST_S + 1);
    localparam logic [1:0] NO_FIX = 2'd0, SYNCED = 2'd1, HOLDOVER = 2'd2;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] S_HOLD = SW'(HOLDOVER_S);
    localparam logic [SW-1:0] S_LOST = SW'(LOST_S);
    localparam logic [5:0] TZ_ADJ = 6'(TZ_HR + 24);

    logic [1:0]    state;
    logic [16:0]   snap;
    logic [4:0]    utc_hr;
    logic [5:0]    utc_min, utc_sec;
    logic [PW-1:0] presc;
    logic [SW-1:0] stale, stale_inc;
    logic          pulse_pend, load, tick, sec_wrap, min_wrap;
    logic [16:0]   in_time;
    logic [5:0]    hr_sum;
    logic [4:0]    loc_hr_next;

    always_comb begin
        in_time     = {gps_hr, gps_min, gps_sec};
        load        = gps_NSR && in_time != snap && gps_hr <= 5'd23 && gps_min <= 6'd59 && gps_sec <= 6'd59;
        tick        = state != NO_FIX && presc == P_MAX;
        stale_inc   = stale == S_LOST ? stale : stale + 1'b1;
        sec_wrap    = utc_sec == 6'd59;
        min_wrap    = utc_min == 6'd59;
        hr_sum      = {1'b0, utc_hr} + TZ_ADJ;
        loc_hr_next = 5'(hr_sum >= 6'd48 ? hr_sum - 6'd48 : hr_sum >= 6'd24 ? hr_sum - 6'd24 : hr_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= NO_FIX;
            snap       <= '0;
            utc_hr     <= '0;
            utc_min    <= '0;
            utc_sec    <= '0;
            presc      <= '0;
            stale      <= '0;
            pulse_pend <= 1'b0;
            loc_hr     <= '0;
            loc_min    <= '0;
            loc_sec    <= '0;
            time_valid <= 1'b0;
            holdover   <= 1'b0;
            sec_pulse  <= 1'b0;
        end else begin
            snap       <= in_time;
            pulse_pend <= tick && !load;
            sec_pulse  <= pulse_pend;
            time_valid <= state != NO_FIX;
            holdover   <= state == HOLDOVER;
            loc_hr     <= state == NO_FIX ? '0 : loc_hr_next;
            loc_min    <= state == NO_FIX ? '0 : utc_min;
            loc_sec    <= state == NO_FIX ? '0 : utc_sec;
            if (load) begin
                utc_hr  <= gps_hr;
                utc_min <= gps_min;
                utc_sec <= gps_sec;
                presc   <= '0;
                stale   <= '0;
                state   <= SYNCED;
            end else begin
                presc <= (state == NO_FIX || tick) ? '0 : presc + 1'b1;
                if (tick) begin
                    utc_sec <= sec_wrap ? 6'd0 : utc_sec + 6'd1;
                    utc_min <= sec_wrap ? (min_wrap ? 6'd0 : utc_min + 6'd1) : utc_min;
                    utc_hr  <= sec_wrap && min_wrap ? (utc_hr == 5'd23 ? 5'd0 : utc_hr + 5'd1) : utc_hr;
                    stale   <= stale_inc;
                    if (state == SYNCED && stale_inc >= S_HOLD)
                        state <= HOLDOVER;
                    // losing the fix discards the coasted time entirely
                    if (state == HOLDOVER && stale_inc >= S_LOST) begin
                        state   <= NO_FIX;
                        utc_hr  <= '0;
                        utc_min <= '0;
                        utc_sec <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gps_time_keeper.sv
// tb_gps_time_keeper: directed scenarios plus randomized traffic checked against a seconds-of-day reference model
module tb_gps_time_keeper;
    localparam int CLK = 10, HOLD = 3, LOST = 6;

    logic       clk = 0, rst = 0;
    logic [4:0] gps_hr = 0;
    logic [5:0] gps_min = 0, gps_sec = 0;
    logic       gps_NSR = 0;
    logic [4:0] loc_hr, loc_hr_b;
    logic [5:0] loc_min, loc_sec, loc_min_b, loc_sec_b;
    logic       time_valid, holdover, sec_pulse, time_valid_b, holdover_b, sec_pulse_b;
    int errors = 0, checks = 0;

    gps_time_keeper #(.CLK_HZ(CLK), .TZ_HR(0), .HOLDOVER_S(HOLD), .LOST_S(LOST)) u_utc (
        .clk(clk), .rst(rst), .gps_hr(gps_hr), .gps_min(gps_min), .gps_sec(gps_sec), .gps_NSR(gps_NSR),
        .loc_hr(loc_hr), .loc_min(loc_min), .loc_sec(loc_sec),
        .time_valid(time_valid), .holdover(holdover), .sec_pulse(sec_pulse));

    gps_time_keeper #(.CLK_HZ(CLK), .TZ_HR(-5), .HOLDOVER_S(HOLD), .LOST_S(LOST)) u_est (
        .clk(clk), .rst(rst), .gps_hr(gps_hr), .gps_min(gps_min), .gps_sec(gps_sec), .gps_NSR(gps_NSR),
        .loc_hr(loc_hr_b), .loc_min(loc_min_b), .loc_sec(loc_sec_b),
        .time_valid(time_valid_b), .holdover(holdover_b), .sec_pulse(sec_pulse_b));

    always #5 clk = ~clk;

    // reference: time kept as seconds of day, status as 0=no fix, 1=synced, 2=holdover
    int m_state, m_tod, m_phase, m_stale, m_snap;
    bit m_pend;
    int e_hr, e_hr_b, e_min, e_sec;
    bit e_valid, e_hold, e_pulse;

    always @(posedge clk) begin : model
        int key;
        bit ld, tk;
        key = gps_hr * 4096 + gps_min * 64 + gps_sec;
        if (!rst) begin
            m_state = 0; m_tod = 0; m_phase = 0; m_stale = 0; m_snap = 0; m_pend = 0;
            e_hr = 0; e_hr_b = 0; e_min = 0; e_sec = 0; e_valid = 0; e_hold = 0; e_pulse = 0;
        end else begin
            ld = gps_NSR && key != m_snap && gps_hr < 24 && gps_min < 60 && gps_sec < 60;
            tk = m_state != 0 && m_phase == CLK - 1;
            e_valid = m_state != 0;
            e_hold  = m_state == 2;
            e_pulse = m_pend;
            e_hr    = e_valid ? m_tod / 3600 : 0;
            e_hr_b  = e_valid ? (m_tod / 3600 + 19) % 24 : 0;
            e_min   = e_valid ? (m_tod / 60) % 60 : 0;
            e_sec   = e_valid ? m_tod % 60 : 0;
            m_pend  = tk && !ld;
            m_snap  = key;
            if (ld) begin
                m_tod = gps_hr * 3600 + gps_min * 60 + gps_sec;
                m_phase = 0; m_stale = 0; m_state = 1;
            end else begin
                if (m_state != 0) m_phase = (m_phase + 1) % CLK;
                if (tk) begin
                    m_tod = (m_tod + 1) % 86400;
                    m_stale = m_stale + 1 > LOST ? LOST : m_stale + 1;
                    if (m_state == 1 && m_stale >= HOLD) m_state = 2;
                    else if (m_state == 2 && m_stale >= LOST) begin
                        m_state = 0; m_tod = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input int h, input int m, input int s, input bit n);
        gps_hr = 5'(h); gps_min = 6'(m); gps_sec = 6'(s); gps_NSR = n;
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, time_valid, holdover, sec_pulse} !== 20'd0)
            begin errors++; $display("FAIL reset_utc got %0d:%0d:%0d v=%b h=%b p=%b want all 0", loc_hr, loc_min, loc_sec, time_valid, holdover, sec_pulse); end
        checks++;
        if ({loc_hr_b, loc_min_b, loc_sec_b, time_valid_b, holdover_b, sec_pulse_b} !== 20'd0)
            begin errors++; $display("FAIL reset_tz got %0d:%0d:%0d v=%b want all 0", loc_hr_b, loc_min_b, loc_sec_b, time_valid_b); end
        rst = 1;
    endtask

    task automatic test_load;
        drive(12, 34, 56, 1);
        @(negedge clk);
        checks++;
        if (time_valid !== 1'b0) begin errors++; $display("FAIL load_latency valid=%b want 0", time_valid); end
        @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, time_valid, holdover} !== {5'd12, 6'd34, 6'd56, 1'b1, 1'b0})
            begin errors++; $display("FAIL load got %0d:%0d:%0d v=%b h=%b want 12:34:56 v=1 h=0", loc_hr, loc_min, loc_sec, time_valid, holdover); end
        checks++;
        if (loc_hr_b !== 5'd7) begin errors++; $display("FAIL load_tz hr=%0d want 7", loc_hr_b); end
    endtask

    task automatic test_rollover;
        int pulses = 0;
        drive(23, 59, 59, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, loc_hr_b} !== {5'd23, 6'd59, 6'd59, 5'd18})
            begin errors++; $display("FAIL roll_pre got %0d:%0d:%0d tz_hr=%0d want 23:59:59 tz_hr=18", loc_hr, loc_min, loc_sec, loc_hr_b); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sec_pulse) begin
                pulses++;
                checks++;
                if ({loc_hr, loc_min, loc_sec, loc_hr_b, loc_min_b, loc_sec_b} !== {5'd0, 6'd0, 6'd0, 5'd19, 6'd0, 6'd0})
                    begin errors++; $display("FAIL roll_post got %0d:%0d:%0d tz=%0d:%0d:%0d want 0:0:0 tz=19:0:0", loc_hr, loc_min, loc_sec, loc_hr_b, loc_min_b, loc_sec_b); end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL roll_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_holdover;
        int n = 0;
        while (!holdover && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (!holdover) begin errors++; $display("FAIL holdover_wait timed out after %0d cycles", n); end
        else begin
            checks++;
            if ({loc_hr, loc_min, loc_sec, time_valid} !== {5'd0, 6'd0, 6'd2, 1'b1})
                begin errors++; $display("FAIL holdover_entry got %0d:%0d:%0d v=%b want 0:0:2 v=1", loc_hr, loc_min, loc_sec, time_valid); end
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!sec_pulse && n < 15);
        checks++;
        if ({loc_sec, holdover, sec_pulse} !== {6'd3, 1'b1, 1'b1})
            begin errors++; $display("FAIL holdover_coast sec=%0d h=%b p=%b want sec=3 h=1 p=1", loc_sec, holdover, sec_pulse); end
        drive(5, 6, 7, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, holdover, time_valid, loc_hr_b} !== {5'd5, 6'd6, 6'd7, 1'b0, 1'b1, 5'd0})
            begin errors++; $display("FAIL holdover_resync got %0d:%0d:%0d h=%b v=%b tz_hr=%0d want 5:6:7 h=0 v=1 tz_hr=0", loc_hr, loc_min, loc_sec, holdover, time_valid, loc_hr_b); end
    endtask

    task automatic test_lost;
        int n = 0, pulses = 0;
        while (time_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (time_valid) begin errors++; $display("FAIL lost_wait timed out after %0d cycles", n); end
        else begin
            checks++;
            if ({loc_hr, loc_min, loc_sec, holdover, sec_pulse} !== {17'd0, 1'b0, 1'b1})
                begin errors++; $display("FAIL lost_entry got %0d:%0d:%0d h=%b p=%b want 0:0:0 h=0 p=1", loc_hr, loc_min, loc_sec, holdover, sec_pulse); end
        end
        for (int i = 0; i < 25; i++) begin @(negedge clk); pulses += int'(sec_pulse); end
        checks++;
        if (pulses != 0 || time_valid) begin errors++; $display("FAIL lost_quiet pulses=%0d v=%b want 0 and 0", pulses, time_valid); end
    endtask

    task automatic test_ignore;
        for (int i = 0; i < 6; i++) begin drive(i, i + 10, i + 20, 0); @(negedge clk); end
        checks++;
        if (time_valid !== 1'b0) begin errors++; $display("FAIL ignore_nsr v=%b want 0", time_valid); end
        for (int i = 0; i < 3; i++) begin drive(25, 10 + i, 10, 1); @(negedge clk); end
        checks++;
        if (time_valid !== 1'b0) begin errors++; $display("FAIL ignore_range v=%b want 0", time_valid); end
        drive(1, 2, 3, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, time_valid} !== {5'd1, 6'd2, 6'd3, 1'b1})
            begin errors++; $display("FAIL ignore_reload got %0d:%0d:%0d v=%b want 1:2:3 v=1", loc_hr, loc_min, loc_sec, time_valid); end
        for (int i = 0; i < 3; i++) begin drive(9, 9, 9 + i, 0); @(negedge clk); end
        drive(25, 0, 0, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, time_valid, holdover} !== {5'd1, 6'd2, 6'd3, 1'b1, 1'b0})
            begin errors++; $display("FAIL ignore_synced got %0d:%0d:%0d v=%b h=%b want 1:2:3 v=1 h=0", loc_hr, loc_min, loc_sec, time_valid, holdover); end
    endtask

    task automatic test_tick_load;
        drive(2, 0, 0, 1);
        repeat (10) @(negedge clk);
        drive(3, 0, 0, 1);
        @(negedge clk);
        checks++;
        if (sec_pulse !== 1'b0) begin errors++; $display("FAIL tick_load_pre p=%b want 0", sec_pulse); end
        @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, sec_pulse} !== {5'd3, 6'd0, 6'd0, 1'b0})
            begin errors++; $display("FAIL tick_load got %0d:%0d:%0d p=%b want 3:0:0 p=0", loc_hr, loc_min, loc_sec, sec_pulse); end
    endtask

    task automatic test_mid_reset;
        drive(4, 4, 4, 1);
        repeat (5) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({loc_hr, loc_min, loc_sec, time_valid, holdover, sec_pulse, loc_hr_b, time_valid_b} !== 26'd0)
            begin errors++; $display("FAIL mid_reset got %0d:%0d:%0d v=%b tz_hr=%0d want all 0", loc_hr, loc_min, loc_sec, time_valid, loc_hr_b); end
        rst = 1;
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if ({loc_hr, loc_min, loc_sec, time_valid, holdover, sec_pulse} !== {5'(e_hr), 6'(e_min), 6'(e_sec), e_valid, e_hold, e_pulse})
                begin errors++; $display("FAIL rand_utc cyc=%0d got %0d:%0d:%0d v=%b h=%b p=%b want %0d:%0d:%0d v=%b h=%b p=%b", c, loc_hr, loc_min, loc_sec, time_valid, holdover, sec_pulse, e_hr, e_min, e_sec, e_valid, e_hold, e_pulse); end
            checks++;
            if ({loc_hr_b, loc_min_b, loc_sec_b, time_valid_b, sec_pulse_b} !== {5'(e_hr_b), 6'(e_min), 6'(e_sec), e_valid, e_pulse})
                begin errors++; $display("FAIL rand_tz cyc=%0d got %0d:%0d:%0d v=%b want %0d:%0d:%0d v=%b", c, loc_hr_b, loc_min_b, loc_sec_b, time_valid_b, e_hr_b, e_min, e_sec, e_valid); end
            if ($urandom_range(0, 49) == 0)
                drive($urandom_range(0, 26), $urandom_range(0, 62), $urandom_range(0, 62), $urandom_range(0, 3) != 0);
            rst = $urandom_range(0, 999) != 0;
        end
        rst = 1;
    endtask

    initial begin
        test_reset;
        test_load;
        test_rollover;
        test_holdover;
        test_lost;
        test_ignore;
        test_tick_load;
        test_mid_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
